// File: rtl/imm_ext_arbiter_pkg.sv
// Shared constants for the immediate-extension arbiter slice: extension mode
// encodings, default widths and the response-slot state type.
package imm_ext_pkg;

    localparam int DEF_IMM_W = 16;
    localparam int DEF_EXT_W = 32;

    localparam logic [1:0] MODE_SEXT   = 2'b00;
    localparam logic [1:0] MODE_ZEXT   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Handshake bundle between the two immediate requesters, the arbiter and the
// response consumer. The arbiter uses the slave modport.
interface imm_ext_arbiter_if
    import imm_ext_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W,
    parameter int EXT_W = DEF_EXT_W
);
    logic             req0_valid;
    logic [IMM_W-1:0] req0_imm;
    logic [1:0]       req0_mode;
    logic             req0_ready;
    logic             req1_valid;
    logic [IMM_W-1:0] req1_imm;
    logic [1:0]       req1_mode;
    logic             req1_ready;
    logic             rsp_valid;
    logic [EXT_W-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;

    modport slave (
        input  req0_valid, req0_imm, req0_mode,
        input  req1_valid, req1_imm, req1_mode,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req0_valid, req0_imm, req0_mode,
        output req1_valid, req1_imm, req1_mode,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/imm_ext_arbiter_unit.sv
// Combinational immediate extender: sign, zero, upper-half and branch-offset
// (word-aligned, sign-extended) forms of a narrow immediate.
module imm_ext_unit
    import imm_ext_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W,
    parameter int EXT_W = DEF_EXT_W
) (
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       mode,
    output logic [EXT_W-1:0] ext
);
    logic sign_s;

    assign sign_s = imm[IMM_W-1];

    // select the extension form
    always_comb begin
        ext = '0;
        case (mode)
            MODE_SEXT:   ext = {{(EXT_W-IMM_W){sign_s}}, imm};
            MODE_ZEXT:   ext = {{(EXT_W-IMM_W){1'b0}}, imm};
            MODE_UPPER:  ext = {imm, {(EXT_W-IMM_W){1'b0}}};
            MODE_BRANCH: ext = {{(EXT_W-IMM_W-2){sign_s}}, imm, 2'b00};
            default:     ext = '0;
        endcase
    end
endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between two requesters,
// with a single registered response slot. Optional grant counters are built
// when IMM_EXT_ARB_STATS_EN is defined.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IMM_W = DEF_IMM_W,
`ifdef IMM_EXT_ARB_STATS_EN
    parameter int EXT_W = DEF_EXT_W,
    parameter int CNT_W = 16
`else
    parameter int EXT_W = DEF_EXT_W
`endif
) (
    input  logic clk,
    input  logic reset,
`ifdef IMM_EXT_ARB_STATS_EN
    imm_ext_arbiter_if.slave bus,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`else
    imm_ext_arbiter_if.slave bus
`endif
);
    slot_state_t      state_r;
    logic             last_grant_r;
    logic [EXT_W-1:0] rsp_data_r;
    logic             rsp_id_r;

    logic             slot_free_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic [IMM_W-1:0] sel_imm_s;
    logic [1:0]       sel_mode_s;
    logic [EXT_W-1:0] ext_s;

    // round-robin grant; the slot may be refilled in the same cycle it drains
    always_comb begin
        slot_free_s = (state_r == SLOT_EMPTY) || bus.rsp_ready;
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        if (!reset && slot_free_s) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_s = last_grant_r;
                grant1_s = !last_grant_r;
            end else begin
                grant0_s = bus.req0_valid;
                grant1_s = bus.req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s = grant0_s || grant1_s;

    // feed the extender from the granted requester
    always_comb begin
        sel_imm_s  = bus.req0_imm;
        sel_mode_s = bus.req0_mode;
        if (grant1_s) begin
            sel_imm_s  = bus.req1_imm;
            sel_mode_s = bus.req1_mode;
        end else begin
            sel_imm_s  = bus.req0_imm;
            sel_mode_s = bus.req0_mode;
        end
    end

    imm_ext_unit #(
        .IMM_W (IMM_W),
        .EXT_W (EXT_W)
    ) u_ext (
        .imm  (sel_imm_s),
        .mode (sel_mode_s),
        .ext  (ext_s)
    );

    // response slot FSM with last-grant tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= SLOT_EMPTY;
            rsp_data_r   <= {EXT_W{1'b0}};
            rsp_id_r     <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            case (state_r)
                SLOT_EMPTY: begin
                    if (accept_s) begin
                        state_r      <= SLOT_FULL;
                        rsp_data_r   <= ext_s;
                        rsp_id_r     <= grant1_s;
                        last_grant_r <= grant1_s;
                    end else begin
                        state_r <= SLOT_EMPTY;
                    end
                end
                SLOT_FULL: begin
                    if (accept_s) begin
                        state_r      <= SLOT_FULL;
                        rsp_data_r   <= ext_s;
                        rsp_id_r     <= grant1_s;
                        last_grant_r <= grant1_s;
                    end else if (bus.rsp_ready) begin
                        state_r <= SLOT_EMPTY;
                    end else begin
                        state_r <= SLOT_FULL;
                    end
                end
                default: state_r <= SLOT_EMPTY;
            endcase
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.rsp_valid  = (state_r == SLOT_FULL);
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_id     = rsp_id_r;

`ifdef IMM_EXT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // saturating per-requester grant counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (grant0_s && (cnt0_r != {CNT_W{1'b1}})) begin
                cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0_r <= cnt0_r;
            end
            if (grant1_s && (cnt1_r != {CNT_W{1'b1}})) begin
                cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

    assign grant_cnt0 = cnt0_r;
    assign grant_cnt1 = cnt1_r;
`endif
endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
- Shares one 16-to-32-bit immediate extension unit between two requesters: requester 0 is decode/ALU operand, requester 1 is the branch-target unit.
- Round-robin arbitration, valid/ready handshakes on both sides, one registered response slot.
- Sits between the decode stage and the ALU/PC-adder operand muxes in the RISC datapath.

Parameters:
- IMM_W, 16, immediate input width.
- EXT_W, 32, extended output width.
- CNT_W, 16, width of the grant counters; used only with IMM_EXT_ARB_STATS_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an immediate.
- req0_imm  in  IMM_W  requester 0 immediate.
- req0_mode  in  2  requester 0 extension mode.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid  in  1  requester 1 has an immediate.
- req1_imm  in  IMM_W  requester 1 immediate.
- req1_mode  in  2  requester 1 extension mode.
- req1_ready  out  1  requester 1 accepted this cycle.
- rsp_valid  out  1  response register holds a result.
- rsp_data  out  EXT_W  extended value.
- rsp_id  out  1  requester that owns rsp_data.
- rsp_ready  in  1  consumer takes the response.
- grant_cnt0  out  CNT_W  present only with IMM_EXT_ARB_STATS_EN.
- grant_cnt1  out  CNT_W  present only with IMM_EXT_ARB_STATS_EN.

Behaviour:
- Reset (synchronous, active-high):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Counters=0.
  - While reset is high, req*_ready=0.
- Response slot states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - slot_free = EMPTY or (FULL and rsp_ready). A drain and a new fill can happen in the same cycle.
- Arbitration (combinational, evaluated only when slot_free):
  - Only reqN_valid: grant N.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = grant to N. At most one ready is high per cycle, and ready never asserts when slot_free=0.
- Accept: on a clock edge with reqN_valid and reqN_ready:
  - rsp_data <= ext(reqN_imm, reqN_mode), rsp_id <= N, rsp_valid <= 1.
  - last_grant <= N.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Drain: on an edge with rsp_valid and rsp_ready and no new accept, rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Hold: while FULL and rsp_ready=0, rsp_data and rsp_id stay stable.
- Requester contract: a requester holds valid, imm and mode stable until it sees ready. The arbiter does not check this.
- Extension modes, with s = imm[15]:
  - 00 sign-extend: {{16{s}}, imm}.
  - 01 zero-extend: {16'b0, imm}.
  - 10 upper: {imm, 16'b0}.
  - 11 branch offset: {{14{s}}, imm, 2'b00}. Bits above bit 31 are truncated.
- Throughput: one result per cycle while rsp_ready=1. Under continuous contention, grants strictly alternate 0,1,0,1.
- Reset asserted mid-operation: any pending response is discarded at that edge, with no partial state kept.

Optional Feature:
- Macro: IMM_EXT_ARB_STATS_EN.
- With the macro defined:
  - grant_cnt0 and grant_cnt1 ports exist.
  - Each counter increments on every accept for its requester and saturates at all-ones.
  - Synchronous reset clears both to 0.
- Without the macro: the ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package imm_ext_pkg holds:
  - Mode constants: MODE_SEXT=2'b00, MODE_ZEXT=2'b01, MODE_UPPER=2'b10, MODE_BRANCH=2'b11.
  - IMM_W and EXT_W defaults.
- Sub-module imm_ext_unit: purely combinational (imm, mode) -> ext, implementing the four modes. The arbiter instantiates it once, fed by the granted requester's mux.
- Arbiter FSM, slot register and counters stay in the top module.

Test Plan:
- Single request: req0_valid=1, imm=16'h8001, mode=00, rsp_ready=1.
  - req0_ready=1 that cycle.
  - Next cycle rsp_valid=1, rsp_data=32'hFFFF8001, rsp_id=0.
- Mode sweep on req1, imm=16'h8003:
  - 01 -> 32'h00008003.
  - 10 -> 32'h80030000.
  - 11 -> 32'hFFFE000C.
  - 00 with imm=16'h7FFF -> 32'h00007FFF.
- Contention: both valid for 4 cycles after reset, rsp_ready=1.
  - Grants go 0,1,0,1.
  - rsp_id sequence 0,1,0,1 with one result per cycle.
- Backpressure: accept one request, then hold rsp_ready=0 for 3 cycles with both requesters valid.
  - Both ready signals stay 0 and rsp_data is stable.
  - When rsp_ready=1, a new grant happens in that same cycle and rsp_valid stays 1 (back-to-back).
- Reset mid-operation: response FULL, assert reset for 1 cycle.
  - rsp_valid=0 next cycle.
  - The following contention grants requester 0 first.
- With IMM_EXT_ARB_STATS_EN: after 5 grants to requester 0 and 3 to requester 1, grant_cnt0=5 and grant_cnt1=3.
  - Preload or long-run check: a counter stops at 16'hFFFF.
